// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: divisor clamp
// minimum, reset-default divisor computation and the per-channel state record.
package clk_div_pkg;

  // Smallest divisor a channel accepts; smaller writes are raised to this.
  localparam int DIV_MIN = 2;

  // Field width of the channel-state record (matches the default CNT_W).
  localparam int STATE_W = 32;

  // Reset-default divisor: input frequency over default output frequency.
  function automatic longint unsigned def_div(input longint unsigned fin,
                                              input longint unsigned fout);
    return (fout == 0) ? 64'd0 : fin / fout;
  endfunction

  // Architectural state of one channel.
  typedef struct packed {
    logic [STATE_W-1:0] cnt;
    logic [STATE_W-1:0] div;
    logic [STATE_W-1:0] shadow;
    logic               pending;
  } ch_state_t;

endpackage

// File: rtl/clk_divider_channel.sv
// One divider channel: period counter, divisor (and optional shadow divisor),
// registered divided clock and tick strobe.
// Optional feature macro: SHADOW_LOAD_EN (divisor writes wait for the wrap).
module clk_divider_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(100)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W:0]   half;
  logic             wrap;
  logic             restart;
`ifdef SHADOW_LOAD_EN
  logic [CNT_W-1:0] shadow_reg, shadow_next;
  logic             pending_reg, pending_next;
`endif

  assign load_val = (load_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : load_div;
  assign wrap     = (cnt_reg == div_reg - CNT_W'(1));

  // Next-state: sync beats load beats free-run; a disabled channel parks at D-1.
  always_comb begin
    div_next     = div_reg;
    cnt_next     = cnt_reg;
    clk_out_next = 1'b0;
    tick_next    = 1'b0;
    restart      = 1'b0;
`ifdef SHADOW_LOAD_EN
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    if (en && sync) begin
      restart      = 1'b1;
      pending_next = 1'b0;
      if (load) begin
        div_next    = load_val;
        shadow_next = load_val;
      end else if (pending_reg) begin
        div_next = shadow_reg;
      end
    end else begin
      if (en && wrap && pending_reg) begin
        div_next     = shadow_reg;
        pending_next = 1'b0;
      end
      if (load) begin
        shadow_next  = load_val;
        pending_next = 1'b1;
      end
    end
`else
    if (load) div_next = load_val;
    restart = en && (sync || load);
`endif
    if (!en)                  cnt_next = div_next - CNT_W'(1);
    else if (restart || wrap) cnt_next = '0;
    else                      cnt_next = cnt_reg + CNT_W'(1);
    // High-phase length computed one bit wider so D = 2^CNT_W-1 cannot overflow.
    half = ({1'b0, div_next} + (CNT_W+1)'(1)) >> 1;
    if (en) begin
      clk_out_next = ({1'b0, cnt_next} < half);
      tick_next    = (cnt_next == div_next - CNT_W'(1));
    end
  end

  // Counter, divisor and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= DEF_DIV - CNT_W'(1);
      div_reg     <= DEF_DIV;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
    end
  end

`ifdef SHADOW_LOAD_EN
  // Shadow divisor and its pending flag.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      shadow_reg  <= DEF_DIV;
      pending_reg <= 1'b0;
    end else begin
      shadow_reg  <= shadow_next;
      pending_reg <= pending_next;
    end
  end
  assign pending = pending_reg;
`else
  assign pending = 1'b0;
`endif

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel runtime-programmable clock divider. NUM_CH independent
// channels share one load port (decoded by load_ch) and one sync strobe.
// Optional feature macro: SHADOW_LOAD_EN (glitch-free deferred divisor load).
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter longint FIN    = 100000000,
  parameter longint FOUT   = 100,
  parameter int     NUM_CH = 4,
  parameter int     CNT_W  = 32,
  localparam int    LCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              load,
  input  logic [LCH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0]  load_div,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(def_div(FIN, FOUT));

  // One channel per output bit; load is routed only to the addressed channel,
  // so an out-of-range load_ch matches nothing.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic load_sel;
    assign load_sel = load && (load_ch == LCH_W'(gi));

    clk_divider_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en[gi]),
      .load     (load_sel),
      .load_div (load_div),
      .sync     (sync),
      .clk_out  (clk_out[gi]),
      .tick     (tick[gi]),
      .pending  (pending[gi])
    );
  end

endmodule
